max_extract_seq: RTL and testbench

MAX_EXTRACT_SEQ -- requirements
Module: max_extract_seq

---
 rtl/sort_pkg.sv | 16 +
 rtl/prio_pick.sv | 27 ++
 rtl/max_extract_seq.sv | 157 +++++++++++++++
 tb/tb_max_extract_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared configuration and state encoding for the sequential max-extraction sorter.
package sort_pkg;

    localparam int unsigned M        = 8;
    localparam int unsigned N        = 8;
    localparam int unsigned CORE_LAT = N - 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPick,
        StOut
    } state_e;

endpackage

// File: rtl/prio_pick.sv
// Lowest-index priority selector: one-hot and binary index of the lowest set bit of mask.
module prio_pick #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]         mask,
    output logic [W-1:0]         onehot,
    output logic [$clog2(W)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(W);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |mask;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/max_extract_seq.sv
// Sorts a set by repeated max extraction through an external max-find core.
// Optional MAX_EXTRACT_CHECK_EN adds a sticky o_err flag for an empty core mask.
module max_extract_seq #(
    parameter int unsigned M = sort_pkg::M,
    parameter int unsigned N = sort_pkg::N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [M-1:0][N-1:0]   i_data,
    output logic [M-1:0][N-1:0]   o_core_chi,
    output logic                  o_core_enable,
    input  logic [M-1:0]          i_core_h,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [N-1:0]          o_data,
    output logic [$clog2(M)-1:0]  o_index,
    output logic                  o_last,
    output logic                  o_busy
`ifdef MAX_EXTRACT_CHECK_EN
    ,
    output logic                  o_err
`endif
);

    import sort_pkg::*;

    localparam int unsigned IW = $clog2(M);
    localparam int unsigned CW = $clog2(CORE_LAT + 1);
    localparam int unsigned KW = $clog2(M + 1);

    state_e              state_q;
    logic [M-1:0][N-1:0] data_q;
    logic [M-1:0]        alive_q;
    logic [CW-1:0]       wait_q;
    logic [KW-1:0]       count_q;

    logic [M-1:0]  sel;
    logic [M-1:0]  sel_oh;
    logic [M-1:0]  alive_oh;
    logic [M-1:0]  pick_oh;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] alive_idx;
    logic [IW-1:0] pick_idx;
    logic          sel_any;
    logic          alive_any;

    always_comb begin
        o_core_chi = '0;
        for (int k = 0; k < M; k++) begin
            o_core_chi[k] = alive_q[k] ? data_q[k] : '0;
        end
    end

    assign sel = i_core_h & alive_q;

    prio_pick #(
        .W (M)
    ) u_pick_sel (
        .mask   (sel),
        .onehot (sel_oh),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    // Fallback when the core reports no live candidate.
    prio_pick #(
        .W (M)
    ) u_pick_alive (
        .mask   (alive_q),
        .onehot (alive_oh),
        .idx    (alive_idx),
        .any    (alive_any)
    );

    assign pick_oh  = sel_any ? sel_oh  : alive_oh;
    assign pick_idx = sel_any ? sel_idx : alive_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            data_q        <= '0;
            alive_q       <= '0;
            wait_q        <= '0;
            count_q       <= '0;
            o_core_enable <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_index       <= '0;
            o_last        <= 1'b0;
            o_busy        <= 1'b0;
`ifdef MAX_EXTRACT_CHECK_EN
            o_err         <= 1'b0;
`endif
        end else begin
            o_core_enable <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        data_q        <= i_data;
                        alive_q       <= '1;
                        count_q       <= '0;
                        o_core_enable <= 1'b1;
                        o_busy        <= 1'b1;
                        state_q       <= StIssue;
`ifdef MAX_EXTRACT_CHECK_EN
                        o_err         <= 1'b0;
`endif
                    end
                end
                StIssue: begin
                    wait_q  <= CW'(CORE_LAT);
                    state_q <= StWait;
                end
                StWait: begin
                    wait_q <= wait_q - CW'(1);
                    if (wait_q == CW'(1)) begin
                        state_q <= StPick;
                    end
                end
                StPick: begin
                    if (alive_any) begin
                        o_data  <= data_q[pick_idx];
                        o_index <= pick_idx;
                        o_last  <= (count_q + KW'(1)) == KW'(M);
                        o_valid <= 1'b1;
                        alive_q <= alive_q & ~pick_oh;
                        count_q <= count_q + KW'(1);
                        state_q <= StOut;
`ifdef MAX_EXTRACT_CHECK_EN
                        if (!sel_any) begin
                            o_err <= 1'b1;
                        end
`endif
                    end else begin
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StOut: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (o_last) begin
                            o_busy  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            o_core_enable <= 1'b1;
                            state_q       <= StIssue;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_max_extract_seq.sv
// Randomised self-checking bench for max_extract_seq with a behavioural max-find core.
module tb_max_extract_seq;

    import sort_pkg::*;

    localparam int unsigned IW = $clog2(M);
    typedef logic [M-1:0][N-1:0] set_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic           i_ready = 1'b1;
    set_t           i_data = '0;
    set_t           o_core_chi;
    logic           o_core_enable;
    logic [M-1:0]   i_core_h;
    logic [M-1:0]   core_h;
    logic           o_valid;
    logic [N-1:0]   o_data;
    logic [IW-1:0]  o_index;
    logic           o_last;
    logic           o_busy;
    bit             zero_core = 1'b0;
`ifdef MAX_EXTRACT_CHECK_EN
    logic           o_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    max_extract_seq u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_data        (i_data),
        .o_core_chi    (o_core_chi),
        .o_core_enable (o_core_enable),
        .i_core_h      (i_core_h),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_index       (o_index),
        .o_last        (o_last),
        .o_busy        (o_busy)
`ifdef MAX_EXTRACT_CHECK_EN
        ,
        .o_err         (o_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] max_mask(input set_t s);
        logic [M-1:0] m;
        int unsigned  mx;
        mx = 0;
        for (int i = 0; i < M; i++) if (s[i] > mx) mx = s[i];
        for (int i = 0; i < M; i++) m[i] = (s[i] == mx);
        return m;
    endfunction

    // Core: samples the set on enable and holds its answer until the next evaluation.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) core_h <= '0;
        else if (o_core_enable) core_h <= max_mask(o_core_chi);
    end
    assign i_core_h = zero_core ? '0 : core_h;

    // Expected emission order: largest value first, lowest index among equals.
    task automatic ref_order(input set_t s, input bit lowest_alive,
                             output int unsigned ev[M], output int unsigned ei[M]);
        bit taken[M];
        int best;
        for (int i = 0; i < M; i++) taken[i] = 1'b0;
        for (int k = 0; k < M; k++) begin
            best = -1;
            for (int i = 0; i < M; i++) begin
                if (!taken[i]) begin
                    if (best < 0) best = i;
                    else if (!lowest_alive && s[i] > s[best]) best = i;
                end
            end
            taken[best] = 1'b1;
            ev[k] = s[best];
            ei[k] = best;
        end
    endtask

    function automatic set_t rand_set();
        set_t s;
        bit   narrow;
        narrow = 1'($urandom_range(0, 1));
        for (int k = 0; k < M; k++) begin
            s[k] = N'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 255));
        end
        return s;
    endfunction

    // ready_mode: 0 always ready, 1 random, 2 stall 5 cycles per output.
    task automatic run_sort(input set_t d, input int ready_mode, input bit poke,
                            input bit lowest_alive);
        int unsigned   ev[M];
        int unsigned   ei[M];
        int            got = 0;
        int            cyc = 0;
        int            en_at = -100;
        int            stall = 0;
        bit            seen = 1'b0;
        logic [N-1:0]  hd = '0;
        logic [IW-1:0] hi = '0;
        ref_order(d, lowest_alive, ev, ei);
        @(negedge clk);
        i_data  = d;
        i_start = 1'b1;
        i_ready = (ready_mode == 0);
        @(negedge clk);
        i_start = 1'b0;
        if (poke) i_data = ~d;
        check_eq("busy_after_start", o_busy, 1);
        if (o_core_enable) en_at = 0;
        while (got < M && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            i_start = poke && (cyc == 15 || cyc == 40);
            if (o_core_enable) en_at = cyc;
            if (o_valid) begin
                check_eq("no_enable_in_out", o_core_enable, 0);
                if (!seen) begin
                    seen  = 1'b1;
                    stall = 0;
                    hd    = o_data;
                    hi    = o_index;
                    check_eq("enable_to_valid_gap", cyc - en_at, CORE_LAT + 2);
                    check_eq("out_data", o_data, ev[got]);
                    check_eq("out_index", o_index, ei[got]);
                    check_eq("out_last", o_last, got == M - 1);
                end else begin
                    check_eq("hold_data", o_data, hd);
                    check_eq("hold_index", o_index, hi);
                end
                case (ready_mode)
                    0:       i_ready = 1'b1;
                    1:       i_ready = ($urandom_range(0, 2) != 0);
                    default: i_ready = (stall >= 5);
                endcase
                stall++;
                if (i_ready) begin
                    got++;
                    seen = 1'b0;
                end
            end
        end
        i_start = 1'b0;
        check_eq("sort_complete", got, M);
        @(negedge clk);
        check_eq("idle_after_sort", o_busy, 0);
        check_eq("valid_after_sort", o_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, o_valid, 0);
        check_eq({tag, "_enable"}, o_core_enable, 0);
        check_eq({tag, "_data"}, o_data, 0);
        check_eq({tag, "_index"}, o_index, 0);
        check_eq({tag, "_last"}, o_last, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_chi_zero"}, 32'(o_core_chi != '0), 0);
`ifdef MAX_EXTRACT_CHECK_EN
        check_eq({tag, "_err"}, o_err, 0);
`endif
    endtask

    task automatic reset_mid_sort(input set_t d);
        int enables = 0;
        int cyc = 0;
        int stray = 0;
        @(negedge clk);
        i_data  = d;
        i_start = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (o_core_enable) enables++;
        while (enables < 4 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (o_core_enable) enables++;
        end
        check_eq("reach_fourth_issue", enables, 4);
        repeat (3) @(negedge clk);
        check_eq("busy_in_wait", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (o_valid || o_busy) stray++;
        end
        check_eq("no_output_after_reset", stray, 0);
    endtask

    initial begin
        set_t d37;
        set_t d;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_t d37;
        set_t d;
        d37[0] = 8'd3;   d37[1] = 8'd200; d37[2] = 8'd17; d37[3] = 8'd200;
        d37[4] = 8'd0;   d37[5] = 8'd5;   d37[6] = 8'd99; d37[7] = 8'd1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_sort(d37, 0, 1'b0, 1'b0);
        run_sort('0, 0, 1'b0, 1'b0);
`ifdef MAX_EXTRACT_CHECK_EN
        check_eq("no_err_all_zero", o_err, 0);
`endif
        run_sort(rand_set(), 2, 1'b0, 1'b0);
        run_sort(rand_set(), 0, 1'b1, 1'b0);
        for (int t = 0; t < 15; t++) begin
            d = rand_set();
            run_sort(d, 1, 1'b0, 1'b0);
        end

        reset_mid_sort(rand_set());
        run_sort(d37, 1, 1'b0, 1'b0);

`ifdef MAX_EXTRACT_CHECK_EN
        zero_core = 1'b1;
        run_sort(d37, 0, 1'b0, 1'b1);
        check_eq("err_set_on_empty_mask", o_err, 1);
        zero_core = 1'b0;
        run_sort(rand_set(), 0, 1'b0, 1'b0);
        check_eq("err_cleared_on_start", o_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
